// File: rtl/ras_shadow_stack_if.sv
// Bundle of IF/ID observation inputs and shadow-stack status outputs for ras_shadow_stack.
// The master side is the core/debugger; the slave side is the shadow stack itself.
interface ras_shadow_stack_if #(
   parameter int PTR_W = 4
);
   logic             ins_valid;
   logic [31:0]      ins;
   logic [31:0]      IF_ID_pres_addr;
   logic [31:0]      IF_ID_dout_rs1;
   logic             fault_clr;
   logic             RAS_rdy;
   logic             violation;
   logic [31:0]      fault_addr;
   logic [PTR_W:0]   depth_cnt;
   logic             overflow;
   logic             underflow;

   modport master (
      output ins_valid, ins, IF_ID_pres_addr, IF_ID_dout_rs1, fault_clr,
      input  RAS_rdy, violation, fault_addr, depth_cnt, overflow, underflow
   );

   modport slave (
      input  ins_valid, ins, IF_ID_pres_addr, IF_ID_dout_rs1, fault_clr,
      output RAS_rdy, violation, fault_addr, depth_cnt, overflow, underflow
   );
endinterface

// File: rtl/ras_shadow_stack.sv
// Return-address shadow stack: pushes link addresses on calls, checks returns against the
// saved address, and stalls fetch (RAS_rdy=0) during the check and after a mismatch.
module ras_shadow_stack #(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              Rst,
   ras_shadow_stack_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_FAULT = 2'd2;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   function automatic logic link_reg(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // JALR target: base plus sign-extended I-immediate, bit 0 forced to zero.
   function automatic logic [31:0] ret_target(input logic signed [31:0] base,
                                              input logic [31:0]        insn);
      logic signed [31:0] imm;
      logic signed [31:0] sum;
      imm = {{20{insn[31]}}, insn[31:20]};
      sum = base + imm;
      return sum & ~32'h1;
   endfunction

   logic [1:0]       state;
   logic [31:0]      stack_mem [DEPTH];
   logic [PTR_W-1:0] top;
   logic [PTR_W:0]   cnt;
   logic             violation_r;
   logic             overflow_r;
   logic             underflow_r;
   logic [31:0]      fault_addr_r;

   logic [31:0]      tgt_p1;
   logic [31:0]      pop_val_p1;
   logic [31:0]      ret_pc_p1;

   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic [4:0]       rs1;
   logic             is_jal;
   logic             is_jalr;
   logic             do_push;
   logic             do_pop;
   logic             accept;
   logic             empty;
   logic             full;
   logic             pop_ok;
   logic [PTR_W-1:0] top_m1;
   logic [31:0]      push_val;
   logic [31:0]      ret_tgt;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic             unused_funct3;

   assign opcode   = bus.ins[6:0];
   assign rd       = bus.ins[11:7];
   assign rs1      = bus.ins[19:15];
   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign unused_funct3 = ^bus.ins[14:12];

   assign do_push  = (is_jal || is_jalr) && link_reg(rd);
   assign do_pop   = is_jalr && link_reg(rs1) && !(link_reg(rd) && (rd == rs1));

   assign accept   = bus.ins_valid && (state == S_IDLE);
   assign empty    = (cnt == '0);
   assign full     = (cnt == CNT_FULL);
   assign pop_ok   = accept && do_pop && !empty;
   assign top_m1   = top - PTR_ONE;
   assign push_val = bus.IF_ID_pres_addr + 32'd4;
   assign ret_tgt  = ret_target(bus.IF_ID_dout_rs1, bus.ins);

   // Pop+push reuses the slot just vacated, so the pointer does not move.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = top;
      if (accept && do_push) begin
         wr_en  = 1'b1;
         wr_idx = pop_ok ? top_m1 : top;
      end
   end

   // ---- stage p0 -> p1: stack write and capture of the return under check ----
   always_ff @(posedge clk) begin
      if (wr_en) begin
         stack_mem[wr_idx] <= push_val;
      end
      if (pop_ok) begin
         tgt_p1     <= ret_tgt;
         pop_val_p1 <= stack_mem[top_m1];
         ret_pc_p1  <= bus.IF_ID_pres_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!Rst) begin
         state        <= S_IDLE;
         top          <= '0;
         cnt          <= '0;
         violation_r  <= 1'b0;
         overflow_r   <= 1'b0;
         underflow_r  <= 1'b0;
         fault_addr_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.fault_clr) begin
                  overflow_r  <= 1'b0;
                  underflow_r <= 1'b0;
               end
               if (accept) begin
                  if (do_pop && empty) begin
                     underflow_r <= 1'b1;
                  end
                  if (pop_ok) begin
                     state <= S_CHECK;
                     if (!do_push) begin
                        top <= top_m1;
                        cnt <= cnt - CNT_ONE;
                     end
                  end else if (do_push) begin
                     top <= top + PTR_ONE;
                     // Full: the write above lands on the oldest slot.
                     if (full) begin
                        overflow_r <= 1'b1;
                     end else begin
                        cnt <= cnt + CNT_ONE;
                     end
                  end
               end
            end
            S_CHECK: begin
               if (bus.fault_clr) begin
                  overflow_r  <= 1'b0;
                  underflow_r <= 1'b0;
               end
               if (tgt_p1 == pop_val_p1) begin
                  state <= S_IDLE;
               end else begin
                  state        <= S_FAULT;
                  violation_r  <= 1'b1;
                  fault_addr_r <= ret_pc_p1;
               end
            end
            S_FAULT: begin
               if (bus.fault_clr) begin
                  state       <= S_IDLE;
                  violation_r <= 1'b0;
                  cnt         <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.RAS_rdy    = (state == S_IDLE);
   assign bus.violation  = violation_r;
   assign bus.fault_addr = fault_addr_r;
   assign bus.depth_cnt  = cnt;
   assign bus.overflow   = overflow_r;
   assign bus.underflow  = underflow_r;

endmodule

// File: tb/tb_ras_shadow_stack.sv
// Directed and randomized bench for ras_shadow_stack against a queue-based reference model.
module tb_ras_shadow_stack;

   localparam int DEPTH = 16;
   localparam int PTR_W = $clog2(DEPTH);

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   ras_shadow_stack_if #(.PTR_W(PTR_W)) bus ();

   ras_shadow_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk (clk),
      .Rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: mode 0 = accepting, 1 = checking a return, 2 = frozen on mismatch.
   logic [31:0] mstk [$];
   int          m_mode;
   logic        m_viol;
   logic        m_ovf;
   logic        m_udf;
   logic [31:0] m_faddr;
   logic [31:0] m_tgt;
   logic [31:0] m_popv;
   logic [31:0] m_pc;

   function automatic logic [31:0] enc_jal(input logic [4:0] rd);
      return {20'h0, rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b1100111};
   endfunction

   function automatic logic is_link(input logic [4:0] r);
      return r == 5'd1 || r == 5'd5;
   endfunction

   task automatic model_reset();
      mstk.delete();
      m_mode  = 0;
      m_viol  = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_faddr = 32'h0;
   endtask

   task automatic model_edge(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                             input logic [31:0] rs1v, input logic clr);
      logic               jal;
      logic               jalr;
      logic               push;
      logic               pop;
      logic signed [11:0] imm12;
      logic [31:0]        se;
      jal   = insn[6:0] == 7'b1101111;
      jalr  = insn[6:0] == 7'b1100111;
      push  = (jal || jalr) && is_link(insn[11:7]);
      pop   = jalr && is_link(insn[19:15]) &&
              !(is_link(insn[11:7]) && insn[11:7] == insn[19:15]);
      imm12 = insn[31:20];
      se    = 32'(imm12);
      case (m_mode)
         0: begin
            if (clr) begin
               m_ovf = 1'b0;
               m_udf = 1'b0;
            end
            if (v) begin
               if (pop) begin
                  if (mstk.size() == 0) begin
                     m_udf = 1'b1;
                  end else begin
                     m_popv = mstk.pop_back();
                     m_tgt  = (rs1v + se) & 32'hFFFF_FFFE;
                     m_pc   = pc;
                     m_mode = 1;
                  end
               end
               if (push) begin
                  if (mstk.size() == DEPTH) begin
                     void'(mstk.pop_front());
                     m_ovf = 1'b1;
                  end
                  mstk.push_back(pc + 32'd4);
               end
            end
         end
         1: begin
            if (clr) begin
               m_ovf = 1'b0;
               m_udf = 1'b0;
            end
            if (m_tgt == m_popv) begin
               m_mode = 0;
            end else begin
               m_mode  = 2;
               m_viol  = 1'b1;
               m_faddr = m_pc;
            end
         end
         default: begin
            if (clr) begin
               m_mode = 0;
               m_viol = 1'b0;
               mstk.delete();
            end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rdy"},   {31'b0, bus.RAS_rdy},   {31'b0, m_mode == 0});
      chk({tag, ".viol"},  {31'b0, bus.violation}, {31'b0, m_viol});
      chk({tag, ".faddr"}, bus.fault_addr,         m_faddr);
      chk({tag, ".depth"}, 32'(bus.depth_cnt),     32'(mstk.size()));
      chk({tag, ".ovf"},   {31'b0, bus.overflow},  {31'b0, m_ovf});
      chk({tag, ".udf"},   {31'b0, bus.underflow}, {31'b0, m_udf});
   endtask

   task automatic cycle(input logic rstv, input logic v, input logic [31:0] insn,
                        input logic [31:0] pc, input logic [31:0] rs1v, input logic clr);
      rst_n               = rstv;
      bus.ins_valid       = v;
      bus.ins             = insn;
      bus.IF_ID_pres_addr = pc;
      bus.IF_ID_dout_rs1  = rs1v;
      bus.fault_clr       = clr;
      if (!rstv) model_reset();
      else       model_edge(v, insn, pc, rs1v, clr);
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.ins_valid = 1'b0;
      bus.fault_clr = 1'b0;
   endtask

   task automatic idle_cycle(input string tag);
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      check_all(tag);
   endtask

   logic [4:0]  regs [4];
   logic [31:0] insn_r;
   logic [31:0] pc_r;
   logic [31:0] rs1_r;
   logic [11:0] imm_r;
   logic signed [11:0] imm_s;
   int          kind;

   initial begin
      checks   = 0;
      failures = 0;
      regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd6;
      rst_n               = 1'b1;
      bus.ins_valid       = 1'b0;
      bus.ins             = 32'h0;
      bus.IF_ID_pres_addr = 32'h0;
      bus.IF_ID_dout_rs1  = 32'h0;
      bus.fault_clr       = 1'b0;
      model_reset();

      // Reset for two cycles
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      check_all("reset");
      chk("reset.rdy_const", {31'b0, bus.RAS_rdy}, 32'd1);

      // Matching call/return
      cycle(1'b1, 1'b1, enc_jal(5'd1), 32'h100, 32'h0, 1'b0);
      check_all("call1");
      chk("call1.depth_const", 32'(bus.depth_cnt), 32'd1);
      cycle(1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'h000), 32'h180, 32'h104, 1'b0);
      check_all("ret1");
      chk("ret1.rdy_low", {31'b0, bus.RAS_rdy}, 32'd0);
      chk("ret1.depth0", 32'(bus.depth_cnt), 32'd0);
      idle_cycle("ret1.after");
      chk("ret1.rdy_back", {31'b0, bus.RAS_rdy}, 32'd1);

      // Mismatched return freezes fetch until fault_clr
      cycle(1'b1, 1'b1, enc_jal(5'd1), 32'h200, 32'h0, 1'b0);
      check_all("call2");
      cycle(1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'h000), 32'h208, 32'h300, 1'b0);
      check_all("ret2.check");
      idle_cycle("ret2.fault");
      chk("ret2.viol", {31'b0, bus.violation}, 32'd1);
      chk("ret2.faddr", bus.fault_addr, 32'h208);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, enc_jal(5'd1), 32'h400, 32'h0, 1'b0);
         check_all("ret2.hold");
      end
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      check_all("ret2.clr");
      chk("ret2.clr_rdy", {31'b0, bus.RAS_rdy}, 32'd1);

      // Overflow, LIFO drain, then underflow
      for (int k = 0; k <= DEPTH; k++) begin
         cycle(1'b1, 1'b1, enc_jal(5'd1), 32'h1000 + 32'(4 * k), 32'h0, 1'b0);
         check_all("ovf.call");
      end
      chk("ovf.flag", {31'b0, bus.overflow}, 32'd1);
      chk("ovf.depth", 32'(bus.depth_cnt), 32'(DEPTH));
      for (int j = 0; j < DEPTH; j++) begin
         cycle(1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'h000), 32'h2000,
               32'h1004 + 32'(4 * (DEPTH - j)), 1'b0);
         check_all("drain.ret");
         idle_cycle("drain.chk");
      end
      chk("drain.noviol", {31'b0, bus.violation}, 32'd0);
      cycle(1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'h000), 32'h2000, 32'h1008, 1'b0);
      check_all("udf");
      chk("udf.flag", {31'b0, bus.underflow}, 32'd1);
      chk("udf.rdy", {31'b0, bus.RAS_rdy}, 32'd1);

      // fault_clr in idle clears sticky flags; then pop+push via JALR x1,8(x5)
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      check_all("flagclr");
      cycle(1'b1, 1'b1, enc_jal(5'd5), 32'h3C, 32'h0, 1'b0);
      check_all("pp.call");
      cycle(1'b1, 1'b1, enc_jalr(5'd1, 5'd5, 12'h008), 32'h80, 32'h38, 1'b0);
      check_all("pp.strobe");
      chk("pp.depth", 32'(bus.depth_cnt), 32'd1);
      idle_cycle("pp.done");
      chk("pp.noviol", {31'b0, bus.violation}, 32'd0);

      // ins_valid during CHECK is ignored
      cycle(1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'h000), 32'h90, 32'h84, 1'b0);
      check_all("ign.ret");
      cycle(1'b1, 1'b1, enc_jal(5'd1), 32'h500, 32'h0, 1'b0);
      check_all("ign.call");
      chk("ign.depth", 32'(bus.depth_cnt), 32'd0);

      // Reset while in CHECK, and while in FAULT
      cycle(1'b1, 1'b1, enc_jal(5'd1), 32'h600, 32'h0, 1'b0);
      cycle(1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'h000), 32'h610, 32'h999, 1'b0);
      check_all("rstchk.pre");
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      check_all("rstchk");
      cycle(1'b1, 1'b1, enc_jal(5'd1), 32'h700, 32'h0, 1'b0);
      cycle(1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'h000), 32'h710, 32'h998, 1'b0);
      idle_cycle("rstflt.pre");
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      check_all("rstflt");
      chk("rstflt.faddr", bus.fault_addr, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         kind  = int'($urandom_range(0, 9));
         pc_r  = $urandom & 32'hFFFF_FFFC;
         imm_r = 12'($urandom_range(0, 4095));
         imm_s = imm_r;
         if (kind < 3)      insn_r = enc_jal(regs[$urandom_range(0, 3)]);
         else if (kind < 9) insn_r = enc_jalr(regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], imm_r);
         else               insn_r = $urandom;
         if (mstk.size() > 0 && $urandom_range(0, 3) != 0)
            rs1_r = mstk[$] - 32'(imm_s) + 32'($urandom_range(0, 1));
         else
            rs1_r = $urandom;
         cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, insn_r, pc_r, rs1_r,
               $urandom_range(0, 15) == 0);
         check_all("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ras_shadow_stack.md
# ras_shadow_stack

Hardware return-address shadow stack that sits directly upstream of the core's fetch/PC-enable logic. It watches each instruction as it enters the IF/ID stage. On a call it pushes the link address. On a return it pops the saved address and checks it against the computed JALR target. The result drives `RAS_rdy`, which the core ANDs into `PC_En`. A mismatched return freezes the PC and raises a sticky violation until software or the debugger clears it.

## Interface
- `DEPTH`, 16: number of stack entries; power of two, 2..64.
- `PTR_W`, $clog2(DEPTH): width of the stack pointer.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `Rst`  in  1  synchronous reset, active-low (0 = reset).
- `ins_valid`  in  1  one-cycle strobe: a new instruction is present in IF/ID this cycle.
- `ins`  in  32  instruction in IF/ID.
- `IF_ID_pres_addr`  in  32  PC of `ins`.
- `IF_ID_dout_rs1`  in  32  forwarded rs1 value for `ins`.
- `fault_clr`  in  1  leaves FAULT and empties the stack.
- `RAS_rdy`  out  1  1 = fetch may advance; feeds core `PC_En`.
- `violation`  out  1  sticky return-address mismatch flag.
- `fault_addr`  out  32  PC of the offending return.
- `depth_cnt`  out  PTR_W+1  number of valid entries (0..DEPTH).
- `overflow`  out  1  sticky: a push occurred while full.
- `underflow`  out  1  sticky: a pop occurred while empty.

## Operation
- Act on `ins` only when `ins_valid`=1 and the state is IDLE. Ignore `ins_valid` in CHECK or FAULT; upstream holds the instruction because `RAS_rdy`=0.
- Decode:
  - link(r) means r ∈ {x1, x5}.
  - JAL (opcode 1101111) or JALR (opcode 1100111) with link(rd) is a push.
  - JALR with link(rs1) and NOT (link(rd) and rd==rs1) is a pop.
  - JALR with link(rd), link(rs1) and rd≠rs1 does both: pop the old entry, then push the new one in the same cycle.
- Push value is IF_ID_pres_addr + 4, mod 2^32.
- Return target is (IF_ID_dout_rs1 + sext(ins[31:20])) & ~32'h1. Both the target and the popped value are registered for CHECK.
- Stack storage:
  - Circular buffer with a top pointer.
  - A push while full overwrites the oldest entry, sets `overflow`, and leaves `depth_cnt`=DEPTH.
  - A pop while empty sets `underflow`, leaves the state in IDLE, does no compare, and never faults.
- FSM:
  - IDLE: on a non-empty pop, go to CHECK. Otherwise stay in IDLE.
  - CHECK: if target == popped value, go to IDLE. Otherwise go to FAULT, set `violation`, and load `fault_addr` with the return's PC.
  - FAULT: hold. When `fault_clr`=1, go to IDLE, clear `violation`, and set `depth_cnt` to 0. `fault_addr`, `overflow` and `underflow` keep their values.
- `RAS_rdy` = (state == IDLE). It is combinational from the state register.
- `fault_clr` while in IDLE or CHECK clears only `overflow` and `underflow`.

## Timing
- Reset values: state IDLE, `RAS_rdy`=1, `violation`=0, `fault_addr`=0, `depth_cnt`=0, `overflow`=0, `underflow`=0. Stack contents are don't-care.
- Push: `ins_valid` at edge T makes `depth_cnt` +1 visible after T. `RAS_rdy` stays 1.
- Return (non-empty):
  - Strobe at T; `depth_cnt` −1 after T.
  - `RAS_rdy`=0 for exactly the cycle after T (CHECK).
  - On a match, `RAS_rdy`=1 again after T+1.
  - On a mismatch, `violation`=1 after T+1 and `RAS_rdy` stays 0 until the edge where `fault_clr` is sampled.
- Pop+push: one strobe; `depth_cnt` unchanged. It enters CHECK against the old top, same as a return.
- Reset asserted mid-CHECK or in FAULT: the next edge returns all outputs to their reset values.

## Test plan
- Reset with Rst=0 for 2 cycles → `RAS_rdy`=1, `depth_cnt`=0, all flags 0.
- JAL x1 at PC 0x100, then JALR x0,0(x1) with rs1=0x104 → `depth_cnt` goes 1→0. `RAS_rdy` is low for exactly 1 cycle. `violation`=0.
- Call at 0x200 pushes 0x204; return with rs1=0x300, imm=0 → FAULT, `violation`=1, `fault_addr`=PC of the return, `RAS_rdy` held 0 for 10 cycles. Then `fault_clr` → `RAS_rdy`=1, `depth_cnt`=0.
- DEPTH+1 calls at PCs 0x1000+4k, then DEPTH returns → `overflow`=1. Every return matches in LIFO order (last target 0x1008). One more return → `underflow`=1 with no fault.
- JALR x1,8(x5): first push 0x40 via JAL x5 from 0x3C, then x5=0x38 → computed target 0x40 matches and passes. Push of PC+4 leaves `depth_cnt`=1.
- `ins_valid` pulsed during CHECK with a call opcode → ignored; `depth_cnt` unchanged.
